// File: rtl/branch_rs.sv
`default_nettype none
// ============================================================================
// Module   : branch_rs
// Purpose  : Reservation station for control-transfer ops; snoops the CDB for
//            missing operands, issues one ready op per cycle to the branch unit.
//            Optional macro BRANCH_RS_LSB_CDB_EN adds a second (load) CDB port.
// Revision : 1.0 - initial release
// ============================================================================
module branch_rs #(
   parameter int RS_SIZE   = 8,
   parameter int TAG_WIDTH = 4,
   parameter int OP_WIDTH  = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 clear,
   input  logic                 disp_enable,
   input  logic [OP_WIDTH-1:0]  disp_op,
   input  logic                 disp_vj_ok,
   input  logic [31:0]          disp_vj,
   input  logic [TAG_WIDTH-1:0] disp_qj,
   input  logic                 disp_vk_ok,
   input  logic [31:0]          disp_vk,
   input  logic [TAG_WIDTH-1:0] disp_qk,
   input  logic [TAG_WIDTH-1:0] disp_dest_rob,
   input  logic [31:0]          disp_imm,
   input  logic [31:0]          disp_pc,
   output logic                 rs_full,
   input  logic                 cdb_valid,
   input  logic [TAG_WIDTH-1:0] cdb_tag,
   input  logic [31:0]          cdb_data,
`ifdef BRANCH_RS_LSB_CDB_EN
   input  logic                 lsb_cdb_valid,
   input  logic [TAG_WIDTH-1:0] lsb_cdb_tag,
   input  logic [31:0]          lsb_cdb_data,
`endif
   output logic                 exec_enable,
   output logic [OP_WIDTH-1:0]  exec_op,
   output logic [31:0]          exec_reg1,
   output logic [31:0]          exec_reg2,
   output logic [TAG_WIDTH-1:0] exec_dest_rob,
   output logic [31:0]          exec_imm,
   output logic [31:0]          exec_pc
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   logic [RS_SIZE-1:0]   r_busy;
   logic [OP_WIDTH-1:0]  r_op     [RS_SIZE];
   logic [RS_SIZE-1:0]   r_vj_ok;
   logic [31:0]          r_vj     [RS_SIZE];
   logic [TAG_WIDTH-1:0] r_qj     [RS_SIZE];
   logic [RS_SIZE-1:0]   r_vk_ok;
   logic [31:0]          r_vk     [RS_SIZE];
   logic [TAG_WIDTH-1:0] r_qk     [RS_SIZE];
   logic [TAG_WIDTH-1:0] r_dest   [RS_SIZE];
   logic [31:0]          r_imm    [RS_SIZE];
   logic [31:0]          r_pc     [RS_SIZE];

   logic                 r_exec_enable;
   logic [OP_WIDTH-1:0]  r_exec_op;
   logic [31:0]          r_exec_reg1;
   logic [31:0]          r_exec_reg2;
   logic [TAG_WIDTH-1:0] r_exec_dest_rob;
   logic [31:0]          r_exec_imm;
   logic [31:0]          r_exec_pc;

   logic [RS_SIZE-1:0]   w_j_hit;
   logic [31:0]          w_j_data [RS_SIZE];
   logic [RS_SIZE-1:0]   w_k_hit;
   logic [31:0]          w_k_data [RS_SIZE];
   logic                 w_dj_hit;
   logic [31:0]          w_dj_data;
   logic                 w_dk_hit;
   logic [31:0]          w_dk_data;

   logic                 w_full;
   logic                 w_free_valid;
   logic [IDX_W-1:0]     w_free_idx;
   logic                 w_sel_valid;
   logic [IDX_W-1:0]     w_sel_idx;
   logic                 w_disp_fire;

   // Returns {hit, data}; the ALU CDB overrides the load CDB on a double match.
   function automatic logic [32:0] snoop(input logic [TAG_WIDTH-1:0] q);
      logic [32:0] res;
      res = '0;
`ifdef BRANCH_RS_LSB_CDB_EN
      if (lsb_cdb_valid && (lsb_cdb_tag == q)) res = {1'b1, lsb_cdb_data};
`endif
      if (cdb_valid && (cdb_tag == q)) res = {1'b1, cdb_data};
      return res;
   endfunction

   generate
      for (genvar i = 0; i < RS_SIZE; i++) begin : g_snoop
         assign {w_j_hit[i], w_j_data[i]} = snoop(r_qj[i]);
         assign {w_k_hit[i], w_k_data[i]} = snoop(r_qk[i]);
      end
   endgenerate

   assign {w_dj_hit, w_dj_data} = snoop(disp_qj);
   assign {w_dk_hit, w_dk_data} = snoop(disp_qk);

   assign w_full      = &r_busy;
   assign w_disp_fire = disp_enable && !w_full;

   // Lowest-index free slot and lowest-index fully ready slot.
   always_comb begin
      w_free_valid = 1'b0;
      w_free_idx   = '0;
      w_sel_valid  = 1'b0;
      w_sel_idx    = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!r_busy[i]) begin
            w_free_valid = 1'b1;
            w_free_idx   = i[IDX_W-1:0];
         end
         if (r_busy[i] && r_vj_ok[i] && r_vk_ok[i]) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = i[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy          <= '0;
         r_exec_enable   <= 1'b0;
         r_exec_op       <= '0;
         r_exec_reg1     <= '0;
         r_exec_reg2     <= '0;
         r_exec_dest_rob <= '0;
         r_exec_imm      <= '0;
         r_exec_pc       <= '0;
      end else if (clear) begin
         r_busy        <= '0;
         r_exec_enable <= 1'b0;
      end else if (!rdy) begin
         r_exec_enable <= 1'b0;
      end else begin
         r_exec_enable <= w_sel_valid;
         if (w_sel_valid) begin
            r_exec_op            <= r_op[w_sel_idx];
            r_exec_reg1          <= r_vj[w_sel_idx];
            r_exec_reg2          <= r_vk[w_sel_idx];
            r_exec_dest_rob      <= r_dest[w_sel_idx];
            r_exec_imm           <= r_imm[w_sel_idx];
            r_exec_pc            <= r_pc[w_sel_idx];
            r_busy[w_sel_idx]    <= 1'b0;
         end
         for (int i = 0; i < RS_SIZE; i++) begin
            if (r_busy[i] && !r_vj_ok[i] && w_j_hit[i]) begin
               r_vj[i]    <= w_j_data[i];
               r_vj_ok[i] <= 1'b1;
            end
            if (r_busy[i] && !r_vk_ok[i] && w_k_hit[i]) begin
               r_vk[i]    <= w_k_data[i];
               r_vk_ok[i] <= 1'b1;
            end
         end
         // The free slot is never the selected one, so these writes cannot collide.
         if (w_disp_fire && w_free_valid) begin
            r_busy[w_free_idx]  <= 1'b1;
            r_op[w_free_idx]    <= disp_op;
            r_vj_ok[w_free_idx] <= disp_vj_ok || w_dj_hit;
            r_vj[w_free_idx]    <= disp_vj_ok ? disp_vj : w_dj_data;
            r_qj[w_free_idx]    <= disp_qj;
            r_vk_ok[w_free_idx] <= disp_vk_ok || w_dk_hit;
            r_vk[w_free_idx]    <= disp_vk_ok ? disp_vk : w_dk_data;
            r_qk[w_free_idx]    <= disp_qk;
            r_dest[w_free_idx]  <= disp_dest_rob;
            r_imm[w_free_idx]   <= disp_imm;
            r_pc[w_free_idx]    <= disp_pc;
         end
      end
   end

   assign rs_full       = w_full;
   assign exec_enable   = r_exec_enable;
   assign exec_op       = r_exec_op;
   assign exec_reg1     = r_exec_reg1;
   assign exec_reg2     = r_exec_reg2;
   assign exec_dest_rob = r_exec_dest_rob;
   assign exec_imm      = r_exec_imm;
   assign exec_pc       = r_exec_pc;

endmodule
`default_nettype wire

// File: tb/tb_branch_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_rs
// Purpose  : Directed self-checking bench for branch_rs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_rs;

   logic        clk = 1'b0;
   logic        rst, rdy, clear;
   logic        disp_enable, disp_vj_ok, disp_vk_ok;
   logic [5:0]  disp_op;
   logic [31:0] disp_vj, disp_vk, disp_imm, disp_pc;
   logic [3:0]  disp_qj, disp_qk, disp_dest_rob;
   logic        rs_full;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        exec_enable;
   logic [5:0]  exec_op;
   logic [31:0] exec_reg1, exec_reg2, exec_imm, exec_pc;
   logic [3:0]  exec_dest_rob;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   branch_rs #(.RS_SIZE(8), .TAG_WIDTH(4), .OP_WIDTH(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .disp_enable(disp_enable), .disp_op(disp_op),
      .disp_vj_ok(disp_vj_ok), .disp_vj(disp_vj), .disp_qj(disp_qj),
      .disp_vk_ok(disp_vk_ok), .disp_vk(disp_vk), .disp_qk(disp_qk),
      .disp_dest_rob(disp_dest_rob), .disp_imm(disp_imm), .disp_pc(disp_pc),
      .rs_full(rs_full),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
`ifdef BRANCH_RS_LSB_CDB_EN
      .lsb_cdb_valid(1'b0), .lsb_cdb_tag(4'd0), .lsb_cdb_data(32'd0),
`endif
      .exec_enable(exec_enable), .exec_op(exec_op),
      .exec_reg1(exec_reg1), .exec_reg2(exec_reg2),
      .exec_dest_rob(exec_dest_rob), .exec_imm(exec_imm), .exec_pc(exec_pc)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      disp_enable = 1'b0;
      cdb_valid   = 1'b0;
      clear       = 1'b0;
   endtask

   task automatic disp(input logic [5:0] op,
                       input logic jok, input logic [31:0] vj, input logic [3:0] qj,
                       input logic kok, input logic [31:0] vk, input logic [3:0] qk,
                       input logic [3:0] dest, input logic [31:0] imm, input logic [31:0] pc);
      disp_enable   = 1'b1;
      disp_op       = op;
      disp_vj_ok    = jok;  disp_vj = vj;  disp_qj = qj;
      disp_vk_ok    = kok;  disp_vk = vk;  disp_qk = qk;
      disp_dest_rob = dest;
      disp_imm      = imm;
      disp_pc       = pc;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
      cdb_valid = 1'b1;
      cdb_tag   = tag;
      cdb_data  = data;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1;
      idle();
      disp(6'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0);
      disp_enable = 1'b0;
      cdb_tag = 4'd0; cdb_data = 32'd0;
      step(); step();
      chk("reset_full", rs_full, 0);
      chk("reset_en", exec_enable, 0);
      chk("reset_pc", exec_pc, 0);
      chk("reset_reg1", exec_reg1, 0);
      rst = 1'b0;

      // 1: ready BEQ issues one edge after dispatch
      disp(6'd1, 1'b1, 32'd5, 4'd0, 1'b1, 32'd5, 4'd0, 4'd2, 32'd8, 32'h100);
      step(); idle();
      chk("t1_no_early", exec_enable, 0);
      step();
      chk("t1_en", exec_enable, 1);
      chk("t1_op", exec_op, 6'd1);
      chk("t1_reg1", exec_reg1, 5);
      chk("t1_reg2", exec_reg2, 5);
      chk("t1_pc", exec_pc, 32'h100);
      chk("t1_imm", exec_imm, 8);
      chk("t1_dest", exec_dest_rob, 2);
      step();
      chk("t1_pulse", exec_enable, 0);
      chk("t1_hold_pc", exec_pc, 32'h100);

      // 2: BNE waits on tag 3, woken by CDB two cycles later
      disp(6'd2, 1'b0, 32'd0, 4'd3, 1'b1, 32'h11, 4'd0, 4'd4, 32'd0, 32'h200);
      step(); idle();
      chk("t2_wait0", exec_enable, 0);
      step();
      chk("t2_wait1", exec_enable, 0);
      cdb(4'd3, 32'h2A);
      step(); idle();
      chk("t2_wake_edge", exec_enable, 0);
      step();
      chk("t2_en", exec_enable, 1);
      chk("t2_reg1", exec_reg1, 32'h2A);
      chk("t2_reg2", exec_reg2, 32'h11);
      chk("t2_pc", exec_pc, 32'h200);
      step();

      // 3: dispatch-time bypass of source2
      disp(6'd3, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd7, 4'd5, 32'd0, 32'h300);
      cdb(4'd7, 32'd9);
      step(); idle();
      chk("t3_no_early", exec_enable, 0);
      step();
      chk("t3_en", exec_enable, 1);
      chk("t3_reg2", exec_reg2, 9);
      chk("t3_pc", exec_pc, 32'h300);
      step();

      // 4: fill all eight slots, ninth ignored, in-order drain
      for (int i = 0; i < 8; i++) begin
         disp(6'd4, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0, 4'(i), 32'd0, 32'h1000 + 32'(4 * i));
         step();
      end
      chk("t4_full", rs_full, 1);
      disp(6'd4, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0, 4'd9, 32'd0, 32'hDEAD);
      step(); idle();
      chk("t4_full_hold", rs_full, 1);
      chk("t4_no_issue", exec_enable, 0);
      cdb(4'd1, 32'h77);
      step(); idle();
      chk("t4_wake_edge", exec_enable, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t4_drain_en", exec_enable, 1);
         chk("t4_drain_pc", exec_pc, 32'h1000 + 32'(4 * i));
         chk("t4_drain_dest", exec_dest_rob, 32'(i));
         if (i == 0) chk("t4_full_drop", rs_full, 0);
      end
      step();
      chk("t4_ninth_dropped", exec_enable, 0);

      // 5: clear flushes waiting entries and a same-cycle dispatch
      for (int i = 0; i < 4; i++) begin
         disp(6'd5, 1'b0, 32'd0, 4'd5, 1'b1, 32'd0, 4'd0, 4'(i), 32'd0, 32'h500);
         step();
      end
      disp(6'd5, 1'b0, 32'd0, 4'd5, 1'b1, 32'd0, 4'd0, 4'd6, 32'd0, 32'h504);
      clear = 1'b1;
      step(); idle();
      chk("t5_full", rs_full, 0);
      chk("t5_en", exec_enable, 0);
      cdb(4'd5, 32'h55);
      step(); idle();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_no_issue", exec_enable, 0);
      end

      // 6: rdy low freezes a ready entry and blocks dispatch
      disp(6'd6, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd8, 32'd0, 32'h600);
      step();
      rdy = 1'b0;
      disp(6'd6, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd9, 32'd0, 32'h700);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_frozen", exec_enable, 0);
      end
      idle();
      rdy = 1'b1;
      step();
      chk("t6_en", exec_enable, 1);
      chk("t6_pc", exec_pc, 32'h600);
      chk("t6_reg1", exec_reg1, 3);
      step();
      chk("t6_no_second", exec_enable, 0);

      // 7: reset mid-operation discards a waiting entry
      disp(6'd7, 1'b0, 32'd0, 4'd9, 1'b1, 32'd0, 4'd0, 4'd1, 32'd0, 32'h800);
      step(); idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t7_reset_en", exec_enable, 0);
      chk("t7_reset_pc", exec_pc, 0);
      cdb(4'd9, 32'h99);
      step(); idle();
      step();
      chk("t7_no_issue", exec_enable, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
